// File: rtl/memory_writeback_cycle.sv
// M and W stages of the RV32 pipeline: byte/half/word data-memory access in M,
// then the M/W register that drives the writeback triple and hazard-unit exports.
module memory_writeback_cycle #(
    parameter int DMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [31:0] ResultW,
    output logic        MisalignW
);

    logic [31:0]       dmem [DMEM_DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic              mis_addr;
    logic              misM;
    logic              mem_we;
    logic [3:0]        byte_en;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;

    logic              regwrite_q, regwrite_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rsrc_q, rsrc_d;
    logic              mis_q, mis_d;

    assign word_idx = ALUResultM[ADDR_W+1:2];
    assign byte_off = ALUResultM[1:0];

    // Store data is replicated across lanes so byte_en alone picks the target bytes.
    always_comb begin
        mis_addr = 1'b0;
        byte_en  = 4'b1111;
        wr_lanes = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << byte_off;
                wr_lanes = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                mis_addr = byte_off[0];
                byte_en  = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WriteDataM[15:0]}};
            end
            default: begin
                mis_addr = |byte_off;
            end
        endcase
    end

    assign misM   = (MemWriteM | ResultSrcM) & mis_addr;
    // Gating with rst drops a store that is caught by reset mid-cycle.
    assign mem_we = rst & MemWriteM & ~misM;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    dmem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = dmem[word_idx];

    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (byte_off)
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        case (funct3M[1:0])
            2'b00:   load_data = {{24{~funct3M[2] & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~funct3M[2] & ld_half[15]}}, ld_half};
            default: load_data = rd_word;
        endcase
        if (mis_addr) begin
            load_data = 32'h0;
        end
    end

    always_comb begin
        regwrite_d = RegWriteM & (RD_M != 5'd0) & ~(ResultSrcM & misM);
        rd_d       = RD_M;
        alu_d      = ALUResultM;
        rdata_d    = load_data;
        rsrc_d     = ResultSrcM;
        mis_d      = misM;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            alu_q      <= 32'h0;
            rdata_q    <= 32'h0;
            rsrc_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            rsrc_q     <= rsrc_d;
            mis_q      <= mis_d;
        end
    end

    assign RegWriteW = regwrite_q;
    assign RDW       = rd_q;
    assign ResultW   = rsrc_q ? rdata_q : alu_q;
    assign MisalignW = mis_q;

endmodule
